// File: rtl/pipeline_pkg.sv
// pipeline_pkg: widths, encodings and the E/M register layout shared by the execute stage.
package pipeline_pkg;

    localparam int DATA_W  = 19;
    localparam int PC_W    = 12;
    localparam int RADDR_W = 5;

    // Counter wide enough to hold DATA_W-1 multiply steps.
    localparam int MUL_CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    typedef struct packed {
        logic               reg_write;
        logic               mem_write;
        logic [1:0]         result_src;
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  write_data;
        logic [RADDR_W-1:0] rd;
        logic [PC_W-1:0]    pc_plus1;
    } em_reg_t;

    localparam em_reg_t EM_BUBBLE = '0;

    function automatic logic [DATA_W-1:0] fwd_select(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (fwd_sel_t'(sel))
            FWD_WB:  return wb_val;
            FWD_MEM: return mem_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/execute_mul.sv
// execute_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// Only the low DATA_W bits of the product are kept.
module execute_mul
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    mul_state_t           state_q, state_d;
    logic [MUL_CNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]    mcand_q, mcand_d;
    logic [DATA_W-1:0]    mplier_q, mplier_d;
    logic [DATA_W-1:0]    acc_q, acc_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    mcand_d  = op_a_i;
                    mplier_d = op_b_i;
                    acc_d    = '0;
                    count_d  = MUL_CNT_W'(DATA_W - 1);
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (count_q == '0) begin
                    state_d = MUL_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = acc_q;

endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, branch/jump resolution and the E/M register.
// Define EXECUTE_MUL_EN to build in the iterative multiplier and its upstream stall.
module execute_stage
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               JumpE,
    input  logic               BranchE,
    input  logic               ALUSrcE,
    input  logic [1:0]         ResultSrcE,
    input  logic [2:0]         ALUControlE,
    input  logic [DATA_W-1:0]  RD1E,
    input  logic [DATA_W-1:0]  RD2E,
    input  logic [DATA_W-1:0]  ImmExtE,
    input  logic [PC_W-1:0]    PCE,
    input  logic [PC_W-1:0]    PCPlus1E,
    input  logic [RADDR_W-1:0] RdE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [DATA_W-1:0]  ResultW,
    output logic               PCSrcE,
    output logic [PC_W-1:0]    PCTargetE,
    output logic               StallE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic [1:0]         ResultSrcM,
    output logic [DATA_W-1:0]  ALUResultM,
    output logic [DATA_W-1:0]  WriteDataM,
    output logic [RADDR_W-1:0] RdM,
    output logic [PC_W-1:0]    PCPlus1M
);

    em_reg_t           em_q, em_d;
    logic [DATA_W-1:0] src_a_e, src_b_e, write_data_e;
    logic [DATA_W-1:0] alu_out_e, alu_result_e;
    logic [4:0]        shamt_e;
    logic              shift_oob_e;
    logic              zero_e;
    logic              is_mul_e;
    logic              stall_e;

    assign src_a_e      = fwd_select(ForwardAE, RD1E, ResultW, em_q.alu_result);
    assign write_data_e = fwd_select(ForwardBE, RD2E, ResultW, em_q.alu_result);
    assign src_b_e      = ALUSrcE ? ImmExtE : write_data_e;

    assign shamt_e     = src_b_e[4:0];
    assign shift_oob_e = (shamt_e >= 5'(DATA_W));
    assign is_mul_e    = (alu_op_t'(ALUControlE) == ALU_MUL);

    always_comb begin
        alu_out_e = '0;
        unique case (alu_op_t'(ALUControlE))
            ALU_ADD: alu_out_e = src_a_e + src_b_e;
            ALU_SUB: alu_out_e = src_a_e - src_b_e;
            ALU_AND: alu_out_e = src_a_e & src_b_e;
            ALU_OR:  alu_out_e = src_a_e | src_b_e;
            ALU_XOR: alu_out_e = src_a_e ^ src_b_e;
            ALU_SHL: alu_out_e = shift_oob_e ? '0 : (src_a_e << shamt_e);
            ALU_SHR: alu_out_e = shift_oob_e ? '0 : (src_a_e >> shamt_e);
            ALU_MUL: alu_out_e = '0;
            default: alu_out_e = '0;
        endcase
    end

    // Branch compare is independent of the opcode so any ALU op can feed a branch.
    assign zero_e = ((src_a_e - src_b_e) == '0);

`ifdef EXECUTE_MUL_EN
    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    execute_mul u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (is_mul_e),
        .op_a_i    (src_a_e),
        .op_b_i    (src_b_e),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // The mul stays in E until DONE, so its arrival in IDLE already holds the pipeline.
    assign stall_e      = (is_mul_e & ~mul_done) | mul_busy;
    assign alu_result_e = is_mul_e ? mul_product : alu_out_e;
`else
    assign stall_e      = 1'b0;
    assign alu_result_e = alu_out_e;
`endif

    assign StallE    = stall_e;
    assign PCSrcE    = (JumpE | (BranchE & zero_e)) & ~stall_e;
    assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

    always_comb begin
        em_d = EM_BUBBLE;
        if (!stall_e) begin
            em_d.reg_write  = RegWriteE;
            em_d.mem_write  = MemWriteE;
            em_d.result_src = ResultSrcE;
            em_d.alu_result = alu_result_e;
            em_d.write_data = write_data_e;
            em_d.rd         = RdE;
            em_d.pc_plus1   = PCPlus1E;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            em_q <= EM_BUBBLE;
        end else begin
            em_q <= em_d;
        end
    end

    assign RegWriteM  = em_q.reg_write;
    assign MemWriteM  = em_q.mem_write;
    assign ResultSrcM = em_q.result_src;
    assign ALUResultM = em_q.alu_result;
    assign WriteDataM = em_q.write_data;
    assign RdM        = em_q.rd;
    assign PCPlus1M   = em_q.pc_plus1;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized self-checking bench for execute_stage against an arithmetic model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE, ResultW;
    logic [11:0] PCE, PCPlus1E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE, StallE;
    logic [11:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [18:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;
    logic [11:0] PCPlus1M;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_alum = '0;

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    execute_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus1E(PCPlus1E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus1M(PCPlus1M)
    );

    always #5 clk = ~clk;

    // Reference ALU from arithmetic definitions, results modulo 2^19.
    function automatic logic [18:0] ref_alu(input int op, input longint a, input longint b);
        longint m;
        longint sh;
        m  = longint'(1) << 19;
        sh = b % 32;
        case (op)
            0: return 19'((a + b) % m);
            1: return 19'((a - b + m) % m);
            2: return 19'(a & b);
            3: return 19'(a | b);
            4: return 19'(a ^ b);
            5: return (sh >= 19) ? 19'(0) : 19'((a * (longint'(1) << sh)) % m);
            6: return (sh >= 19) ? 19'(0) : 19'(a / (longint'(1) << sh));
            default: return MUL_EN ? 19'((a * b) % m) : 19'(0);
        endcase
    endfunction

    function automatic logic [18:0] ref_fwd(input logic [1:0] sel, input logic [18:0] r);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return exp_alum;
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b,
                         input logic [18:0] imm, input logic alusrc);
        ALUControlE = op; RD1E = a; RD2E = b; ImmExtE = imm; ALUSrcE = alusrc;
        ForwardAE = 2'd0; ForwardBE = 2'd0; JumpE = 1'b0; BranchE = 1'b0;
        RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'd0; RdE = 5'd3;
        PCE = 12'h100; PCPlus1E = 12'h101;
    endtask

    task automatic expect_bubble(input string name);
        checks++;
        if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus1M} !== '0) begin
            errors++;
            $display("FAIL %s: M = %0h %0h %0h %0h %0h %0h %0h, required all zero", name,
                     RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus1M);
        end
    endtask

    task automatic expect_alu(input string name, input logic [18:0] exp);
        checks++;
        if (ALUResultM !== exp) begin
            errors++;
            $display("FAIL %s: ALUResultM=%0h required %0h", name, ALUResultM, exp);
        end
        exp_alum = exp;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE} = 5'($urandom);
        ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom_range(0, 6));
        RD1E = 19'($urandom); RD2E = 19'($urandom); ImmExtE = 19'($urandom); ResultW = 19'($urandom);
        PCE = 12'($urandom); PCPlus1E = 12'($urandom); RdE = 5'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_bubble("reset_m_outputs");
        exp_alum = '0;
        drive(3'd0, 19'd0, 19'd0, 19'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (StallE !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: StallE=%0b required 0", StallE);
        end
    endtask

    task automatic test_add_forward();
        drive(3'd0, 19'd7, 19'd0, 19'd0, 1'b1);
        @(posedge clk); #1;
        expect_alu("fwd_setup", 19'd7);
        drive(3'd0, 19'd5, 19'd0, 19'd3, 1'b1);
        ForwardAE = 2'b10; ResultW = 19'd999;
        @(posedge clk); #1;
        expect_alu("add_forward_mem", 19'd10);
    endtask

    task automatic test_wrap_shift();
        logic [2:0]  ops [4] = '{3'd0, 3'd5, 3'd5, 3'd6};
        logic [18:0] as  [4] = '{19'h7FFFF, 19'd1, 19'd1, 19'h40000};
        logic [18:0] bs  [4] = '{19'd1, 19'd18, 19'd19, 19'd18};
        logic [18:0] ex  [4] = '{19'd0, 19'h40000, 19'd0, 19'd1};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i], 19'd0, 1'b0);
            @(posedge clk); #1;
            expect_alu($sformatf("wrap_shift_%0d", i), ex[i]);
        end
    endtask

    task automatic test_branch();
        drive(3'd1, 19'd9, 19'd9, 19'd4, 1'b0);
        BranchE = 1'b1; PCE = 12'hFFE;
        @(negedge clk);
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 12'h002) begin
            errors++;
            $display("FAIL branch_taken: PCSrcE=%0b PCTargetE=%0h required 1 002", PCSrcE, PCTargetE);
        end
        RD2E = 19'd8;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken: PCSrcE=%0b required 0", PCSrcE);
        end
        @(posedge clk); #1;
        exp_alum = 19'd1;
    endtask

    task automatic test_random();
        logic [18:0] sa, wd, sb, exp_alu;
        logic        exp_pcsrc;
        for (int n = 0; n < 200; n++) begin
            ALUControlE = MUL_EN ? 3'($urandom_range(0, 6)) : 3'($urandom);
            {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE} = 5'($urandom);
            ResultSrcE = 2'($urandom); RdE = 5'($urandom);
            RD1E = 19'($urandom); ResultW = 19'($urandom);
            RD2E = ($urandom_range(0, 3) == 0) ? RD1E : 19'($urandom);
            ImmExtE = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 24)) : 19'($urandom);
            PCE = 12'($urandom); PCPlus1E = 12'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            sa = ref_fwd(ForwardAE, RD1E);
            wd = ref_fwd(ForwardBE, RD2E);
            sb = ALUSrcE ? ImmExtE : wd;
            exp_alu   = ref_alu(int'(ALUControlE), longint'(sa), longint'(sb));
            exp_pcsrc = JumpE || (BranchE && sa == sb);
            @(negedge clk);
            checks++;
            if (PCSrcE !== exp_pcsrc || PCTargetE !== 12'((PCE + ImmExtE) % 4096) || StallE !== 1'b0) begin
                errors++;
                $display("FAIL random_e_%0d: PCSrcE=%0b tgt=%0h stall=%0b required %0b %0h 0", n,
                         PCSrcE, PCTargetE, StallE, exp_pcsrc, 12'((PCE + ImmExtE) % 4096));
            end
            @(posedge clk); #1;
            checks++;
            if ({RegWriteM, MemWriteM, ResultSrcM, WriteDataM, RdM, PCPlus1M} !==
                {RegWriteE, MemWriteE, ResultSrcE, wd, RdE, PCPlus1E}) begin
                errors++;
                $display("FAIL random_m_%0d: wd=%0h rd=%0h pc1=%0h required %0h %0h %0h", n,
                         WriteDataM, RdM, PCPlus1M, wd, RdE, PCPlus1E);
            end
            expect_alu($sformatf("random_alu_%0d", n), exp_alu);
        end
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic run_mul(input string name, input logic [18:0] a, input logic [18:0] b,
                           input logic [18:0] exp);
        int stall_cycles = 0;
        drive(3'd7, 19'd0, b, 19'd0, 1'b0);
        ForwardAE = 2'b01; ResultW = a; RdE = 5'd9;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!StallE) break;
            stall_cycles++;
            checks++;
            if (PCSrcE !== 1'b0) begin
                errors++;
                $display("FAIL %s_pcsrc_in_stall: PCSrcE=%0b required 0", name, PCSrcE);
            end
            JumpE = 1'b1;
            ResultW = 19'($urandom);
            @(posedge clk); #1;
            expect_bubble($sformatf("%s_bubble_%0d", name, i));
        end
        checks++;
        if (stall_cycles != 20) begin
            errors++;
            $display("FAIL %s_stall_len: stalled %0d cycles required 20", name, stall_cycles);
        end
        @(posedge clk); #1;
        checks++;
        if (RegWriteM !== 1'b1 || RdM !== 5'd9) begin
            errors++;
            $display("FAIL %s_ctrl: RegWriteM=%0b RdM=%0d required 1 9", name, RegWriteM, RdM);
        end
        expect_alu(name, exp);
    endtask

    task automatic test_mul();
        run_mul("mul_123x45", 19'd123, 19'd45, 19'(ref_alu(7, 123, 45)));
        run_mul("mul_wrap", 19'h7FFFF, 19'd2, 19'h7FFFE);
    endtask

    task automatic test_reset_busy();
        drive(3'd7, 19'd77, 19'd66, 19'd0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(3'd0, 19'd20, 19'd22, 19'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        expect_bubble("reset_busy_bubble");
        exp_alum = '0;
        @(negedge clk);
        checks++;
        if (StallE !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_stall: StallE=%0b required 0", StallE);
        end
        @(posedge clk); #1;
        expect_alu("add_after_reset", 19'd42);
    endtask
`else
    task automatic test_mul_disabled();
        drive(3'd7, 19'd123, 19'd45, 19'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (StallE !== 1'b0) begin
            errors++;
            $display("FAIL mul_off_stall: StallE=%0b required 0", StallE);
        end
        @(posedge clk); #1;
        expect_alu("mul_off_result", 19'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_add_forward();
        test_wrap_shift();
        test_branch();
        test_random();
`ifdef EXECUTE_MUL_EN
        test_mul();
        test_reset_busy();
`else
        test_mul_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
